// File: rtl/rc5_key_sched.sv
// RC5-16/r/16 key schedule: expands a 128-bit key into t = 2(r+1) 16-bit subkeys.
// Optional macro RC5_KEYSCHED_LOCK_EN hides the table until an expansion completes.
module rc5_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [4:0]   rd_addr,
  output logic [15:0]  rd_data
);
  // state | meaning
  // IDLE  | waiting for start; table readable
  // LOAD  | key words and t captured
  // INIT  | S[k] = P + k*Q, one entry per cycle
  // MIX   | 3*max(t,8) mixing steps over S and L
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, DONE} state_t;

  localparam logic [15:0] P_C = 16'hB7E1;
  localparam logic [15:0] Q_C = 16'h9E37;

  state_t      state_q, state_d;
  logic [5:0]  t_q;
  logic [4:0]  i_q;
  logic [2:0]  j_q;
  logic [15:0] a_q, b_q;
  logic [6:0]  cnt_q;
  logic        kv_q;
  logic [15:0] s_q [32];
  logic [15:0] l_q [8];

  logic        i_last;
  logic [6:0]  mix_len_m1;
  logic [15:0] init_val, a_new, ab_sum, b_new;

  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] w;
    w = {x, x} << n;
    return w[31:16];
  endfunction

  assign i_last     = ({1'b0, i_q} == t_q - 6'd1);
  assign mix_len_m1 = (t_q < 6'd8) ? 7'd23 : ({1'b0, t_q} + {t_q, 1'b0}) - 7'd1;
  assign init_val   = (i_q == 5'd0) ? P_C : s_q[i_q - 5'd1] + Q_C;
  assign a_new      = rotl(s_q[i_q] + a_q + b_q, 4'd3);
  assign ab_sum     = a_new + b_q;
  assign b_new      = rotl(l_q[j_q] + ab_sum, ab_sum[3:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = INIT;
      INIT:    if (i_last) state_d = MIX;
      MIX:     if (cnt_q == 7'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      i_q     <= 5'd0;
      j_q     <= 3'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      cnt_q   <= 7'd0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          // operands captured on the accepting edge so later input changes cannot leak in
          t_q  <= ({2'b00, num_rounds} + 6'd1) << 1;
          kv_q <= 1'b0;
        end
        LOAD: i_q <= 5'd0;
        INIT: begin
          i_q <= i_q + 5'd1;
          if (i_last) begin
            i_q   <= 5'd0;
            j_q   <= 3'd0;
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            cnt_q <= mix_len_m1;
          end
        end
        MIX: begin
          a_q   <= a_new;
          b_q   <= b_new;
          i_q   <= i_last ? 5'd0 : i_q + 5'd1;
          j_q   <= j_q + 3'd1;
          cnt_q <= cnt_q - 7'd1;
          if (cnt_q == 7'd0) kv_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table storage carries no reset; t = 0 after reset makes it unreadable.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == IDLE && start) begin
        for (int k = 0; k < 8; k++) l_q[k] <= key[16*k +: 16];
      end else if (state_q == INIT) begin
        s_q[i_q] <= init_val;
      end else if (state_q == MIX) begin
        s_q[i_q] <= a_new;
        l_q[j_q] <= b_new;
      end
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if ({1'b0, rd_addr} < t_q) rd_data = s_q[rd_addr];
`ifdef RC5_KEYSCHED_LOCK_EN
    if (!kv_q) rd_data = 16'h0000;
`endif
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign key_valid = kv_q;

endmodule

// File: tb/tb_rc5_key_sched.sv
// Bench for rc5_key_sched: vector table plus random runs against a software RC5 key schedule.
module tb_rc5_key_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   num_rounds = 4'd0;
  logic [127:0] key = '0;
  logic         busy, done, key_valid;
  logic [4:0]   rd_addr = 5'd0;
  logic [15:0]  rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rc5_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds), .key(key),
    .busy(busy), .done(done), .key_valid(key_valid), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    int           r;
    logic [127:0] k;
    int           exp_cyc;
    int           inject;
  } vec_t;

  vec_t        vt [6];
  logic [15:0] ms [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mrot(input logic [15:0] x, input int n);
    logic [31:0] xx, r;
    xx = {16'h0000, x};
    r  = (xx << n) | (xx >> (16 - n));
    return r[15:0];
  endfunction

  // Textbook RC5 key expansion with w=16, b=16.
  task automatic build_model(input int r, input logic [127:0] k);
    int t, m, i, j;
    logic [15:0] a, b, s;
    logic [15:0] l [8];
    t = 2 * (r + 1);
    m = 3 * ((t > 8) ? t : 8);
    for (int q = 0; q < 8; q++) l[q] = k[16*q +: 16];
    for (int q = 0; q < 32; q++) ms[q] = 16'h0000;
    ms[0] = 16'hB7E1;
    for (int q = 1; q < t; q++) ms[q] = ms[q-1] + 16'h9E37;
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < m; n++) begin
      a = mrot(ms[i] + a + b, 3);
      s = a + b;
      b = mrot(l[j] + s, int'(s % 16'd16));
      ms[i] = a;
      l[j]  = b;
      i = (i + 1) % t;
      j = (j + 1) % 8;
    end
  endtask

  function automatic logic [127:0] rkey();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic run(input vec_t v);
    int t, cyc, done_cyc, ndone;
    logic [15:0] e0, e1;
    t = 2 * (v.r + 1);
    build_model(v.r, v.k);
`ifdef RC5_KEYSCHED_LOCK_EN
    e0 = 16'h0000; e1 = 16'h0000;
`else
    e0 = 16'hB7E1; e1 = 16'h5618;
`endif
    @(negedge clk);
    num_rounds = 4'(v.r); key = v.k; start = 1'b1;
    @(posedge clk); cyc = 1;
    @(negedge clk);
    start = 1'b0; num_rounds = 4'($urandom_range(0, 15)); key = rkey();
    check("busy_first", busy, 1);
    check("kv_clear", key_valid, 0);
    done_cyc = -1; ndone = 0;
    while (cyc < 200) begin
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        check("kv_with_done", key_valid, 1);
      end
      if (cyc == t + 2) begin
        rd_addr = 5'd0; #1 check("early_s0", rd_data, e0);
        rd_addr = 5'd1; #1 check("early_s1", rd_data, e1);
      end
      if (v.inject != 0 && cyc == v.inject) begin
        start = 1'b1; num_rounds = 4'($urandom_range(0, 15)); key = rkey();
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check("done_cycle", done_cyc, v.exp_cyc);
    check("done_pulses", ndone, 1);
    check("busy_len", cyc, v.exp_cyc + 1);
    check("kv_after", key_valid, 1);
    for (int a = 0; a < 32; a++) begin
      rd_addr = 5'(a);
      #1 check($sformatf("S[%0d]", a), rd_data, (a < t) ? ms[a] : 16'h0000);
    end
  endtask

  initial begin
    vec_t v;
    int ndone;
    vt[0] = '{r: 0,  k: '0,     exp_cyc: 28,  inject: 0};
    vt[1] = '{r: 15, k: rkey(), exp_cyc: 130, inject: 0};
    vt[2] = '{r: 12, k: rkey(), exp_cyc: 106, inject: 0};
    vt[3] = '{r: 3,  k: rkey(), exp_cyc: 34,  inject: 15};
    vt[4] = '{r: 7,  k: rkey(), exp_cyc: 66,  inject: 40};
    vt[5] = '{r: 1,  k: rkey(), exp_cyc: 30,  inject: 0};

    // start held during reset must be ignored
    rst = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kv", key_valid, 0);
    rd_addr = 5'd0; #1 check("rst_rd", rd_data, 16'h0000);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("idle_after_rst", busy, 0);

    for (int n = 0; n < 6; n++) run(vt[n]);

    // abort in the middle of MIX
    @(negedge clk);
    num_rounds = 4'd5; key = rkey(); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (23) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_kv", key_valid, 0);
    rd_addr = 5'd0; #1 check("abort_rd", rd_data, 16'h0000);
    ndone = 0;
    repeat (100) begin
      @(posedge clk); @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", busy, 0);
    run('{r: 5, k: rkey(), exp_cyc: 2 + 12 + 36, inject: 0});

    for (int n = 0; n < 4; n++) begin
      int r, t;
      r = $urandom_range(0, 15);
      t = 2 * (r + 1);
      v = '{r: r, k: rkey(), exp_cyc: 2 + t + 3 * ((t > 8) ? t : 8),
            inject: (n == 1) ? t + 6 : 0};
      run(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
